sliding_window_gen: RTL and testbench
=====================================

SLIDING_WINDOW_GEN -- requirements
Module: sliding_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning pixel width in bits (FP32 bit pattern, never interpreted).
REQ-002 SHALL have parameter IMG_W, default 299, meaning pixels per row; legal range K..1023.
REQ-003 SHALL have parameter IMG_H, default 299, meaning rows per frame; legal range K..1023.
REQ-004 SHALL have parameter K, default 3, meaning window size; legal values 1, 3, 5 or 7.
REQ-005 SHALL have parameter STRIDE, default 1, meaning window step in both axes; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates occur on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; it is asynchronous and active-low (0 = reset asserted).
REQ-008 SHALL have port valid_in, input, 1 bit, meaning pxl_in is valid this cycle.
REQ-009 SHALL have port sof_in, input, 1 bit, meaning the start of frame; it is qualified by valid_in.
REQ-010 SHALL have port pxl_in, input, DATA_WIDTH bits, meaning the raster-order pixel.
REQ-011 SHALL have port win_out, output, K*K*DATA_WIDTH bits, meaning the KxK window.
REQ-012 SHALL have port valid_out, output, 1 bit, meaning win_out is valid this cycle.
REQ-013 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse after the last pixel of a frame.

Function
REQ-014 SHALL accept a pixel only in cycles where valid_in=1; when valid_in=0, all counters, line buffers and window registers SHALL hold.
REQ-015 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) for the accepted pixel; col wraps to 0 and increments row at IMG_W-1; row wraps to 0 at IMG_H-1 with col wrap.
REQ-016 SHALL store the last K-1 rows in line buffers, each IMG_W x DATA_WIDTH, and hold a KxK window register array that shifts one column per accepted pixel.
REQ-017 SHALL pack win_out so that element (r,c) is at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 is the leftmost column, and (K-1,K-1) is the newest pixel.
REQ-018 SHALL treat a pixel as window-completing when all of the following hold: row>=K-1, col>=K-1, (row-(K-1)) mod STRIDE=0 and (col-(K-1)) mod STRIDE=0; stride phase SHALL be tracked with counters, not dividers.
REQ-019 SHALL assert valid_out exactly 1 cycle after accepting a window-completing pixel, with win_out registered in the same cycle; otherwise valid_out=0.
REQ-020 SHALL hold win_out at its last value while valid_out=0.
REQ-021 SHALL emit exactly ((IMG_W-K)/STRIDE+1)*((IMG_H-K)/STRIDE+1) windows per frame, using integer division.
REQ-022 SHALL pulse frame_done for 1 cycle, 1 cycle after accepting pixel (IMG_H-1, IMG_W-1), coincident with that pixel's valid_out if any.
REQ-023 SHALL, on an accepted pixel with sof_in=1, treat that pixel as (0,0) regardless of counter state; a partial previous frame SHALL be abandoned without frame_done, and no window SHALL contain pre-sof rows.
REQ-024 SHALL ignore sof_in when valid_in=0.
REQ-025 SHALL, for K=1, pass each pixel (subject to stride) with latency 1 and instantiate no line buffers.
REQ-026 SHALL allow back-to-back frames with no idle cycle between them.

Reset
REQ-027 SHALL, while reset=0, immediately force valid_out=0, frame_done=0, win_out=0, col=0, row=0 and stride phases=0.
REQ-028 SHALL leave line buffer contents unspecified after reset; they SHALL never be visible on win_out before being overwritten, by REQ-018.
REQ-029 SHALL, when reset is asserted mid-frame, abandon the frame; the first accepted pixel after release SHALL be (0,0).

Verification
REQ-030 SHALL be covered by this scenario: IMG_W=5, IMG_H=4, K=3, STRIDE=1, pixels 0..19 applied continuously -> 6 windows are produced; the first window is {0,1,2,5,6,7,10,11,12}, 1 cycle after pixel 12; the last window is {7,8,9,12,13,14,17,18,19}; frame_done occurs with the last window.
REQ-031 SHALL be covered by this scenario: IMG_W=5, IMG_H=5, K=3, STRIDE=2, pixels 0..24 -> exactly 4 windows are produced, {0,1,2,5,6,7,10,11,12}, {2,3,4,7,8,9,12,13,14}, {10..12,15..17,20..22} and {12..14,17..19,22..24}.
REQ-032 SHALL be covered by this scenario: the REQ-030 stream with random valid_in gaps -> the window sequence is identical; each valid_out occurs 1 cycle after its completing pixel; outputs hold during gaps.
REQ-033 SHALL be covered by this scenario: sof_in=1 asserted at pixel 8 of frame 1, then a full frame 2 -> no frame_done for frame 1, and frame 2 windows match REQ-030 exactly.
REQ-034 SHALL be covered by this scenario: reset=0 pulsed at pixel 11, then pixels 0..19 applied -> outputs are 0 during reset, and afterwards the outputs match REQ-030.
REQ-035 SHALL be covered by this scenario: K=1, STRIDE=1, pixels 0..19 -> 20 windows are produced, each equal to the input pixel and delayed 1 cycle.

Source files
------------

// File: rtl/sliding_window_gen.sv
// Streaming KxK window generator: K-1 line buffers feed a shifting window
// register; completed windows (subject to stride) are presented one cycle later.
module sliding_window_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W      = 299,
    parameter int IMG_H      = 299,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    input  logic                         sof_in,
    input  logic [DATA_WIDTH-1:0]        pxl_in,
    output logic [K*K*DATA_WIDTH-1:0]    win_out,
    output logic                         valid_out,
    output logic                         frame_done
);

    localparam int            CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int            RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic          PH_LAST  = 1'(STRIDE - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_ph_q, col_ph_d;
    logic          row_ph_q, row_ph_d;

    logic [DATA_WIDTH-1:0] win_q [K][K];
    logic [DATA_WIDTH-1:0] win_d [K][K];

    logic [K*K*DATA_WIDTH-1:0] win_out_q, win_out_d;
    logic                      valid_out_q, valid_out_d;
    logic                      frame_done_q, frame_done_d;

    logic                  sof_take;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         eff_row;
    logic                  eff_col_ph;
    logic                  eff_row_ph;
    logic                  col_armed;
    logic                  row_armed;
    logic                  win_done;
    logic                  frame_last;
    logic [DATA_WIDTH-1:0] new_col [K];

    // A start-of-frame pixel is taken as (0,0) whatever the counters say.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first; a path that skips an assignment would otherwise infer a latch.
        sof_take   = valid_in & sof_in;
        eff_col    = sof_take ? '0   : col_q;
        eff_row    = sof_take ? '0   : row_q;
        eff_col_ph = sof_take ? 1'b0 : col_ph_q;
        eff_row_ph = sof_take ? 1'b0 : row_ph_q;
        col_armed  = int'(eff_col) >= K - 1;
        row_armed  = int'(eff_row) >= K - 1;
        win_done   = valid_in & col_armed & row_armed & ~eff_col_ph & ~eff_row_ph;
        frame_last = valid_in & (eff_col == COL_LAST) & (eff_row == ROW_LAST);
    end

    // Stride phase starts counting once the position reaches K-1.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (valid_in) begin
            if (eff_col == COL_LAST) begin
                col_d    = '0;
                col_ph_d = 1'b0;
                if (eff_row == ROW_LAST) begin
                    row_d    = '0;
                    row_ph_d = 1'b0;
                end else begin
                    row_d    = eff_row + RW'(1);
                    row_ph_d = row_armed ? ((eff_row_ph == PH_LAST) ? 1'b0 : eff_row_ph + 1'b1) : 1'b0;
                end
            end else begin
                col_d    = eff_col + CW'(1);
                col_ph_d = col_armed ? ((eff_col_ph == PH_LAST) ? 1'b0 : eff_col_ph + 1'b1) : 1'b0;
                row_d    = eff_row;
                row_ph_d = eff_row_ph;
            end
        end
    end

    generate
        if (K == 1) begin : g_no_lb
            always_comb begin
                new_col[0] = pxl_in;
            end
        end else begin : g_lb
            // lb_mem[0] holds the previous row, lb_mem[K-2] the oldest one.
            logic [DATA_WIDTH-1:0] lb_mem [K-1][IMG_W];
            logic [DATA_WIDTH-1:0] lb_rd  [K-1];

            always_comb begin
                for (int i = 0; i < K - 1; i++) begin
                    lb_rd[i] = lb_mem[i][eff_col];
                end
                for (int r = 0; r < K - 1; r++) begin
                    new_col[r] = lb_rd[K-2-r];
                end
                new_col[K-1] = pxl_in;
            end

            // NOTE: line buffers are deliberately left without reset; row/col gating keeps stale data off win_out, and resetless storage maps onto RAM.
            always_ff @(posedge clk) begin
                if (valid_in) begin
                    lb_mem[0][eff_col] <= pxl_in;
                    for (int i = 1; i < K - 1; i++) begin
                        lb_mem[i][eff_col] <= lb_rd[i-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        win_d = win_q;
        if (valid_in) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = new_col[r];
            end
        end
    end

    // The output register only loads on a completing pixel, so it holds otherwise.
    always_comb begin
        win_out_d = win_out_q;
        if (win_done) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_out_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
                end
            end
        end
        valid_out_d  = win_done;
        frame_done_d = frame_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            col_ph_q     <= 1'b0;
            row_ph_q     <= 1'b0;
            win_q        <= '{default: '0};
            win_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
            col_q        <= col_d;
            row_q        <= row_d;
            col_ph_q     <= col_ph_d;
            row_ph_q     <= row_ph_d;
            win_q        <= win_d;
            win_out_q    <= win_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_out    = win_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen: three configurations share one pixel stream and
// are compared every cycle against a frame-image reference model.
module tb_sliding_window_gen;

    localparam int WB = 288;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        sof_in;
    logic [31:0] pxl_in;

    logic [WB-1:0] win_a, win_b;
    logic [31:0]   win_c;
    logic          vo_a, vo_b, vo_c;
    logic          fd_a, fd_b, fd_c;

    always #5 clk = ~clk;

    sliding_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(4), .K(3), .STRIDE(1)) u_a (
        .clk(clk), .reset(reset), .valid_in(valid_in), .sof_in(sof_in), .pxl_in(pxl_in),
        .win_out(win_a), .valid_out(vo_a), .frame_done(fd_a));

    sliding_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5), .K(3), .STRIDE(2)) u_b (
        .clk(clk), .reset(reset), .valid_in(valid_in), .sof_in(sof_in), .pxl_in(pxl_in),
        .win_out(win_b), .valid_out(vo_b), .frame_done(fd_b));

    sliding_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(4), .K(1), .STRIDE(1)) u_c (
        .clk(clk), .reset(reset), .valid_in(valid_in), .sof_in(sof_in), .pxl_in(pxl_in),
        .win_out(win_c), .valid_out(vo_c), .frame_done(fd_c));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference model: stores every accepted pixel at its (row,col) in a frame
    // image and cuts windows straight out of that image.
    int          m_w [3] = '{5, 5, 5};
    int          m_h [3] = '{4, 5, 4};
    int          m_k [3] = '{3, 3, 1};
    int          m_s [3] = '{1, 2, 1};
    int          m_col [3];
    int          m_row [3];
    logic [31:0] img [3][5][5];
    logic [WB-1:0] exp_win [3];
    logic          exp_vld [3];
    logic          exp_done [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_col[i] = 0; m_row[i] = 0;
            exp_win[i] = '0; exp_vld[i] = 1'b0; exp_done[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int k, s, r, c;
        logic [WB-1:0] w;
        for (int i = 0; i < 3; i++) begin
            exp_vld[i]  = 1'b0;
            exp_done[i] = 1'b0;
            if (valid_in === 1'b1) begin
                if (sof_in === 1'b1) begin m_col[i] = 0; m_row[i] = 0; end
                k = m_k[i]; s = m_s[i]; r = m_row[i]; c = m_col[i];
                img[i][r][c] = pxl_in;
                if (r >= k - 1 && c >= k - 1 && (r - k + 1) % s == 0 && (c - k + 1) % s == 0) begin
                    w = '0;
                    for (int rr = 0; rr < k; rr++)
                        for (int cc = 0; cc < k; cc++)
                            w[(rr*k+cc)*32 +: 32] = img[i][r-k+1+rr][c-k+1+cc];
                    exp_win[i] = w;
                    exp_vld[i] = 1'b1;
                end
                if (r == m_h[i] - 1 && c == m_w[i] - 1) exp_done[i] = 1'b1;
                if (c == m_w[i] - 1) begin
                    c = 0;
                    r = (r == m_h[i] - 1) ? 0 : r + 1;
                end else begin
                    c = c + 1;
                end
                m_col[i] = c; m_row[i] = r;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    // Per-cycle comparison plus capture of the deterministic opening stream.
    logic          chk_en = 1'b0;
    logic          cap_en = 1'b0;
    logic [WB-1:0] cap_a[$], cap_b[$], cap_c[$];
    int            done_n [3] = '{0, 0, 0};
    logic [WB-1:0] done_win_a;
    logic          done_vld_a;

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_valid", WB'(vo_a), WB'(exp_vld[0]));
            check("a_done",  WB'(fd_a), WB'(exp_done[0]));
            check("a_win",   win_a,     exp_win[0]);
            check("b_valid", WB'(vo_b), WB'(exp_vld[1]));
            check("b_done",  WB'(fd_b), WB'(exp_done[1]));
            check("b_win",   win_b,     exp_win[1]);
            check("c_valid", WB'(vo_c), WB'(exp_vld[2]));
            check("c_done",  WB'(fd_c), WB'(exp_done[2]));
            check("c_win",   WB'(win_c), exp_win[2]);
        end
        if (cap_en) begin
            if (vo_a) cap_a.push_back(win_a);
            if (vo_b) cap_b.push_back(win_b);
            if (vo_c) cap_c.push_back(WB'(win_c));
            if (fd_a) begin done_n[0]++; done_win_a = win_a; done_vld_a = vo_a; end
            if (fd_b) done_n[1]++;
            if (fd_c) done_n[2]++;
        end
    end

    function automatic logic [WB-1:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {32'(a8), 32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] p);
        valid_in = v;
        sof_in   = s;
        pxl_in   = p;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_len();
        case ($urandom_range(0, 2))
            0:       return 20;
            1:       return 25;
            default: return $urandom_range(2, 30);
        endcase
    endfunction

    logic [WB-1:0] b_exp [4];
    int            rem;
    logic          v, s;

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        pxl_in   = '0;
        #1 reset = 1'b0;
        chk_en   = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Deterministic opening: pixels 0..24 with no gaps.
        cap_en = 1'b1;
        for (int p = 0; p < 25; p++) drive(1'b1, p == 0, 32'(p));
        repeat (4) drive(1'b0, 1'b0, 32'hdead_beef);
        cap_en = 1'b0;

        check("a_nwin",     WB'(cap_a.size()), WB'(6));
        check("a_first",    (cap_a.size() > 0) ? cap_a[0] : '0, mk9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        check("a_last",     (cap_a.size() > 5) ? cap_a[5] : '0, mk9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        check("a_ndone",    WB'(done_n[0]), WB'(1));
        check("a_done_vld", WB'(done_vld_a), WB'(1));
        check("a_done_win", done_win_a, mk9(7, 8, 9, 12, 13, 14, 17, 18, 19));

        b_exp[0] = mk9(0, 1, 2, 5, 6, 7, 10, 11, 12);
        b_exp[1] = mk9(2, 3, 4, 7, 8, 9, 12, 13, 14);
        b_exp[2] = mk9(10, 11, 12, 15, 16, 17, 20, 21, 22);
        b_exp[3] = mk9(12, 13, 14, 17, 18, 19, 22, 23, 24);
        check("b_nwin",  WB'(cap_b.size()), WB'(4));
        check("b_ndone", WB'(done_n[1]), WB'(1));
        for (int i = 0; i < 4; i++)
            check($sformatf("b_w%0d", i), (cap_b.size() > i) ? cap_b[i] : '0, b_exp[i]);

        check("c_nwin",  WB'(cap_c.size()), WB'(25));
        check("c_ndone", WB'(done_n[2]), WB'(1));
        for (int i = 0; i < 25; i++)
            check($sformatf("c_w%0d", i), (cap_c.size() > i) ? cap_c[i] : '0, WB'(i));

        // Randomized phase: gaps, random frame lengths (abandoned frames via
        // early sof, natural wraps via long ones) and one mid-stream reset.
        rem = 0;
        for (int j = 0; j < 1600; j++) begin
            if (j == 800) begin reset = 1'b0; rem = 0; end
            if (j == 804) reset = 1'b1;
            v = ($urandom_range(0, 3) != 0);
            s = 1'b0;
            if (v) begin
                if (rem == 0) begin s = 1'b1; rem = pick_len(); end
                rem--;
            end
            drive(v, s, $urandom);
        end
        repeat (3) drive(1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
